// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcode encodings and FSM states for alu_seq (ALU_SEQ_DIV_EN adds DIV)
package alu_seq_pkg;

    localparam logic [3:0] OP_EXT  = 4'b0000;
    localparam logic [3:0] OP_CMP  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_DEC  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_ADD  = 4'b0111;
    localparam logic [3:0] OP_MOVB = 4'b1000;
    localparam logic [3:0] OP_COM  = 4'b1001;
    localparam logic [3:0] OP_INC  = 4'b1010;
    localparam logic [3:0] OP_MOVA = 4'b1011;
    localparam logic [3:0] OP_SHL  = 4'b1100;
    localparam logic [3:0] OP_CLR  = 4'b1101;
    localparam logic [3:0] OP_SHR  = 4'b1110;
    localparam logic [3:0] OP_SUBC = 4'b1111;

    localparam logic [2:0] MOP_MUL  = 3'b000;
    localparam logic [2:0] MOP_DIV  = 3'b001;
    localparam logic [2:0] MOP_RRC  = 3'b100;
    localparam logic [2:0] MOP_RLC  = 3'b101;
    localparam logic [2:0] MOP_CPLC = 3'b110;
    localparam logic [2:0] MOP_CLRC = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DONE
`ifdef ALU_SEQ_DIV_EN
        , DIV
`endif
    } state_t;

    // True for opcodes that run on the iterative datapath
    function automatic logic is_multi(input logic [3:0] op, input logic [2:0] mop);
`ifdef ALU_SEQ_DIV_EN
        return (op == OP_EXT) && ((mop == MOP_MUL) || (mop == MOP_DIV));
`else
        return (op == OP_EXT) && (mop == MOP_MUL);
`endif
    endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// rtl/alu_seq_iter.sv - shared shift-add multiply / restoring divide datapath (divide under ALU_SEQ_DIV_EN)
module alu_seq_iter #(
    parameter int W  = 8,
    parameter int CW = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
`ifdef ALU_SEQ_DIV_EN
    input  logic         div_sel,
`endif
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         last,
    output logic [W-1:0] hi_next,
    output logic [W-1:0] lo_next
);

    // acc: product high half / remainder; sreg: multiplier / dividend-quotient; opnd: multiplicand / divisor
    logic [W-1:0]  acc;
    logic [W-1:0]  sreg;
    logic [W-1:0]  opnd;
    logic [CW-1:0] cnt;
    logic [W:0]    sum;

    assign sum  = {1'b0, acc} + (sreg[0] ? {1'b0, opnd} : {(W+1){1'b0}});
    assign last = (cnt == CW'(W - 1));

`ifdef ALU_SEQ_DIV_EN
    logic         div_mode;
    logic [W:0]   shifted;
    logic         too_small;
    logic [W-1:0] rem_try;

    assign shifted   = {acc, sreg[W-1]};
    assign too_small = shifted < {1'b0, opnd};
    // The true difference is below 2^W whenever it is kept, so modular W-bit subtraction is exact
    assign rem_try   = shifted[W-1:0] - opnd;
`endif

    // One iteration: shift-add for multiply, shift-subtract-restore for divide
    always_comb begin
        hi_next = sum[W:1];
        lo_next = {sum[0], sreg[W-1:1]};
`ifdef ALU_SEQ_DIV_EN
        if (div_mode) begin
            if (too_small) begin
                hi_next = shifted[W-1:0];
                lo_next = {sreg[W-2:0], 1'b0};
            end else begin
                hi_next = rem_try;
                lo_next = {sreg[W-2:0], 1'b1};
            end
        end
`endif
    end

    // Operand load on the Start edge, then one iteration per busy cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            sreg <= '0;
            opnd <= '0;
            cnt  <= '0;
        end else if (load) begin
            acc <= '0;
            cnt <= '0;
`ifdef ALU_SEQ_DIV_EN
            sreg <= div_sel ? a : b;
            opnd <= div_sel ? b : a;
`else
            sreg <= b;
            opnd <= a;
`endif
        end else if (step) begin
            acc  <= hi_next;
            sreg <= lo_next;
            cnt  <= cnt + CW'(1);
        end
    end

`ifdef ALU_SEQ_DIV_EN
    // Remember which operation the iterations belong to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_mode <= 1'b0;
        end else if (load) begin
            div_mode <= div_sel;
        end
    end
`endif

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with Z/C flags and multi-cycle MUL (divide under ALU_SEQ_DIV_EN)
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = $clog2(W + 1)
) (
    input  logic         CLK,
    input  logic         Reset_n,
    input  logic         Start,
    input  logic [3:0]   OP,
    input  logic [2:0]   MOP,
    input  logic [W-1:0] InputA,
    input  logic [W-1:0] InputB,
    output logic [W-1:0] Out,
    output logic [W-1:0] OutHi,
    output logic         ZeroOut,
    output logic         CarryOut,
    output logic         Busy,
    output logic         Done
);

    state_t       state;
    state_t       state_next;
    logic         accept;
    logic         start_multi;
    logic         start_mul;
    logic         step;
    logic         last;
    logic [W-1:0] hi_next;
    logic [W-1:0] lo_next;
    logic [W-1:0] s_out;
    logic         s_z;
    logic         s_c;
    logic         upd_z;
    logic [W:0]   add_w;
    logic [W:0]   sub_w;
    logic [W:0]   subc_w;

    // Start is only looked at while not busy, which makes DONE a valid accept cycle
    assign accept      = Start && ((state == IDLE) || (state == DONE));
    assign start_multi = accept && is_multi(OP, MOP);
    assign start_mul   = accept && (OP == OP_EXT) && (MOP == MOP_MUL);

`ifdef ALU_SEQ_DIV_EN
    logic start_div;
    logic div_b_zero;
    assign start_div = accept && (OP == OP_EXT) && (MOP == MOP_DIV);
    assign step      = (state == MULT) || (state == DIV);
`else
    assign step      = (state == MULT);
`endif

    alu_seq_iter #(.W(W), .CW(CW)) u_iter (
        .clk     (CLK),
        .rst_n   (Reset_n),
        .load    (start_multi),
        .step    (step),
`ifdef ALU_SEQ_DIV_EN
        .div_sel (start_div),
`endif
        .a       (InputA),
        .b       (InputB),
        .last    (last),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

    assign add_w  = {1'b0, InputA} + {1'b0, InputB};
    assign sub_w  = {1'b0, InputA} - {1'b0, InputB};
    assign subc_w = sub_w - {{W{1'b0}}, CarryOut};

    // FSM state register
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                state_next = IDLE;
                if (start_mul) state_next = MULT;
`ifdef ALU_SEQ_DIV_EN
                else if (start_div) state_next = DIV;
`endif
                else if (accept) state_next = DONE;
            end
            MULT: if (last) state_next = DONE;
`ifdef ALU_SEQ_DIV_EN
            DIV:  if (last) state_next = DONE;
`endif
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        Busy = 1'b0;
        Done = 1'b0;
        case (state)
            MULT: Busy = 1'b1;
`ifdef ALU_SEQ_DIV_EN
            DIV:  Busy = 1'b1;
`endif
            DONE: Done = 1'b1;
            default: ;
        endcase
    end

    // Single-cycle result and flags; anything not assigned holds its current value
    always_comb begin
        s_out = Out;
        s_z   = ZeroOut;
        s_c   = CarryOut;
        upd_z = 1'b0;
        case (OP)
            OP_EXT: begin
                case (MOP)
                    MOP_RRC: begin
                        s_out = {CarryOut, InputB[W-1:1]};
                        s_c   = InputB[0];
                    end
                    MOP_RLC: begin
                        s_out = {InputB[W-2:0], CarryOut};
                        s_c   = InputB[W-1];
                    end
                    MOP_CPLC: s_c = ~CarryOut;
                    MOP_CLRC: s_c = 1'b0;
                    default: ;
                endcase
            end
            OP_CMP: begin
                s_out = '0;
                if (MOP[2]) s_c = (InputA < InputB);
                else        s_z = (InputA == InputB);
            end
            OP_SUB:  begin s_out = sub_w[W-1:0];  s_c = sub_w[W];  upd_z = 1'b1; end
            OP_SUBC: begin s_out = subc_w[W-1:0]; s_c = subc_w[W]; upd_z = 1'b1; end
            OP_DEC:  begin s_out = InputA - W'(1); upd_z = 1'b1; end
            OP_INC:  begin s_out = InputA + W'(1); upd_z = 1'b1; end
            OP_ADD:  begin s_out = add_w[W-1:0];  s_c = add_w[W];  upd_z = 1'b1; end
            OP_OR:   begin s_out = InputA | InputB; upd_z = 1'b1; end
            OP_AND:  begin s_out = InputA & InputB; upd_z = 1'b1; end
            OP_XOR:  begin s_out = InputA ^ InputB; upd_z = 1'b1; end
            OP_COM:  begin s_out = ~InputA; upd_z = 1'b1; end
            OP_MOVB: s_out = InputB;
            OP_MOVA: s_out = InputA;
            OP_CLR:  begin s_out = '0; upd_z = 1'b1; end
            OP_SHL:  begin s_out = {InputA[W-2:0], 1'b0}; s_c = InputA[W-1]; upd_z = 1'b1; end
            OP_SHR:  begin s_out = {1'b0, InputA[W-1:1]}; s_c = InputA[0];   upd_z = 1'b1; end
            default: ;
        endcase
        if (upd_z) s_z = (s_out == '0);
    end

`ifdef ALU_SEQ_DIV_EN
    // Divide-by-zero is decided from the divisor seen on the Start edge
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            div_b_zero <= 1'b0;
        end else if (start_div) begin
            div_b_zero <= (InputB == '0);
        end
    end
`endif

    // Result and flag registers change only on the edge that enters DONE
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            Out      <= '0;
            OutHi    <= '0;
            ZeroOut  <= 1'b0;
            CarryOut <= 1'b0;
        end else if (accept && !start_multi) begin
            Out      <= s_out;
            OutHi    <= '0;
            ZeroOut  <= s_z;
            CarryOut <= s_c;
        end else if ((state == MULT) && last) begin
            Out      <= lo_next;
            OutHi    <= hi_next;
            ZeroOut  <= ({hi_next, lo_next} == '0);
            CarryOut <= (hi_next != '0);
        end
`ifdef ALU_SEQ_DIV_EN
        else if ((state == DIV) && last) begin
            Out      <= lo_next;
            OutHi    <= hi_next;
            ZeroOut  <= (lo_next == '0);
            CarryOut <= div_b_zero;
        end
`endif
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq at W=8 (DIV steps when ALU_SEQ_DIV_EN is defined)
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] op;
    logic [2:0] mop;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [7:0] out;
    logic [7:0] out_hi;
    logic       zero;
    logic       carry;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic [7:0] e_out;
        logic [7:0] e_hi;
        logic       e_z;
        logic       e_c;
        bit         chk_out;
        int         e_lat;
        int         e_busy;
    } exp_t;

    exp_t sb[$];

    alu_seq #(.W(8)) dut (
        .CLK      (clk),
        .Reset_n  (rst_n),
        .Start    (start),
        .OP       (op),
        .MOP      (mop),
        .InputA   (in_a),
        .InputB   (in_b),
        .Out      (out),
        .OutHi    (out_hi),
        .ZeroOut  (zero),
        .CarryOut (carry),
        .Busy     (busy),
        .Done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_exp(input string tag, input logic [7:0] e_out, input logic [7:0] e_hi,
                            input logic e_z, input logic e_c, input bit chk_out,
                            input int e_lat, input int e_busy);
        exp_t e;
        e.tag = tag; e.e_out = e_out; e.e_hi = e_hi; e.e_z = e_z; e.e_c = e_c;
        e.chk_out = chk_out; e.e_lat = e_lat; e.e_busy = e_busy;
        sb.push_back(e);
    endtask

    // Pop the oldest expectation and compare it against the outputs seen with Done high
    task automatic pop_check(input int lat, input int busy_cnt);
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ":latency"}, lat, e.e_lat);
        chk({e.tag, ":busy_cycles"}, busy_cnt, e.e_busy);
        if (e.chk_out) chk({e.tag, ":out"}, out, e.e_out);
        chk({e.tag, ":out_hi"}, out_hi, e.e_hi);
        chk({e.tag, ":zero"}, zero, e.e_z);
        chk({e.tag, ":carry"}, carry, e.e_c);
    endtask

    // Issue one operation, scramble inputs after the Start edge, optionally poke Start while busy
    task automatic run_op(input string tag, input logic [3:0] o, input logic [2:0] m,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] e_out, input logic [7:0] e_hi,
                          input logic e_z, input logic e_c, input bit chk_out,
                          input int e_lat, input int e_busy, input int poke);
        int busy_cnt;
        int done_k;
        push_exp(tag, e_out, e_hi, e_z, e_c, chk_out, e_lat, e_busy);
        @(negedge clk);
        start = 1'b1; op = o; mop = m; in_a = a; in_b = b;
        busy_cnt = 0;
        done_k = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0; in_a = ~a; in_b = ~b; op = OP_SUB; mop = 3'b111;
            end
            if (k == poke) begin
                start = 1'b1; op = OP_ADD; mop = 3'b000; in_a = 8'h01; in_b = 8'h01;
            end
            if (k == poke + 1) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                done_k = k;
                break;
            end
        end
        if (done_k == 0) begin
            chk({tag, ":done_timeout"}, 32'd0, 32'd1);
            void'(sb.pop_front());
        end else begin
            pop_check(done_k, busy_cnt);
        end
        @(negedge clk);
        chk({tag, ":pulse_end"}, {busy, done}, 2'b00);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 4'h0; mop = 3'h0; in_a = 8'h00; in_b = 8'h00;
        #12;
        chk("reset:out", out, 8'h00);
        chk("reset:out_hi", out_hi, 8'h00);
        chk("reset:flags", {zero, carry}, 2'b00);
        chk("reset:busy_done", {busy, done}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add_pre", OP_ADD, 3'b000, 8'hF0, 8'h20, 8'h10, 8'h00, 1'b0, 1'b1, 1, 1, 0, 0);

        // Asynchronous reset in the middle of a multiply
        @(negedge clk);
        start = 1'b1; op = OP_EXT; mop = MOP_MUL; in_a = 8'hFF; in_b = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midmul:busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("midmul_rst:out", out, 8'h00);
        chk("midmul_rst:flags", {zero, carry}, 2'b00);
        chk("midmul_rst:busy_done", {busy, done}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add",    OP_ADD,  3'b000,   8'hF0, 8'h20, 8'h10, 8'h00, 1'b0, 1'b1, 1, 1, 0, 0);
        run_op("sub",    OP_SUB,  3'b000,   8'h10, 8'h10, 8'h00, 8'h00, 1'b1, 1'b0, 1, 1, 0, 0);
        run_op("cplc",   OP_EXT,  MOP_CPLC, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 0, 1, 0, 0);
        run_op("rrc",    OP_EXT,  MOP_RRC,  8'h00, 8'h02, 8'h81, 8'h00, 1'b1, 1'b0, 1, 1, 0, 0);
        run_op("rlc",    OP_EXT,  MOP_RLC,  8'h00, 8'h80, 8'h00, 8'h00, 1'b1, 1'b1, 1, 1, 0, 0);
        run_op("subc_c1", OP_SUBC, 3'b000,  8'h05, 8'h05, 8'hFF, 8'h00, 1'b0, 1'b1, 1, 1, 0, 0);
        run_op("clrc",   OP_EXT,  MOP_CLRC, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 0, 1, 0, 0);
        run_op("subc_c0", OP_SUBC, 3'b000,  8'h05, 8'h05, 8'h00, 8'h00, 1'b1, 1'b0, 1, 1, 0, 0);
        run_op("mul_ff", OP_EXT,  MOP_MUL,  8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b1, 1, 9, 8, 4);
        run_op("inc",    OP_INC,  3'b000,   8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1, 1, 0, 0);
        run_op("dec",    OP_DEC,  3'b000,   8'h00, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1, 1, 1, 0, 0);
        run_op("shl",    OP_SHL,  3'b000,   8'h81, 8'h00, 8'h02, 8'h00, 1'b0, 1'b1, 1, 1, 0, 0);
        run_op("shr",    OP_SHR,  3'b000,   8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1, 1, 0, 0);
        run_op("xor",    OP_XOR,  3'b000,   8'h5A, 8'hFF, 8'hA5, 8'h00, 1'b0, 1'b1, 1, 1, 0, 0);
        run_op("cmp_eq", OP_CMP,  3'b000,   8'h03, 8'h03, 8'h00, 8'h00, 1'b1, 1'b1, 1, 1, 0, 0);
        run_op("cmp_ge", OP_CMP,  3'b100,   8'h04, 8'h03, 8'h00, 8'h00, 1'b1, 1'b0, 1, 1, 0, 0);
        run_op("cmp_lt", OP_CMP,  3'b100,   8'h02, 8'h03, 8'h00, 8'h00, 1'b1, 1'b1, 1, 1, 0, 0);
        run_op("or",     OP_OR,   3'b000,   8'h0F, 8'hF0, 8'hFF, 8'h00, 1'b0, 1'b1, 1, 1, 0, 0);
        run_op("com",    OP_COM,  3'b000,   8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1, 1, 0, 0);
        run_op("and",    OP_AND,  3'b000,   8'h0F, 8'hF0, 8'h00, 8'h00, 1'b1, 1'b1, 1, 1, 0, 0);
        run_op("add_nc", OP_ADD,  3'b000,   8'h7F, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 1, 1, 0, 0);
        run_op("mul_0",  OP_EXT,  MOP_MUL,  8'h00, 8'h37, 8'h00, 8'h00, 1'b1, 1'b0, 1, 9, 8, 0);
        run_op("mul_100", OP_EXT, MOP_MUL,  8'h10, 8'h10, 8'h00, 8'h01, 1'b0, 1'b1, 1, 9, 8, 0);

        // Back-to-back: second Start accepted in the DONE cycle of the first
        push_exp("b2b_add",  8'h02, 8'h00, 1'b0, 1'b0, 1, 1, 0);
        push_exp("b2b_mova", 8'h3C, 8'h00, 1'b0, 1'b0, 1, 1, 0);
        @(negedge clk);
        start = 1'b1; op = OP_ADD; mop = 3'b000; in_a = 8'h01; in_b = 8'h01;
        @(negedge clk);
        chk("b2b_add:done", done, 1'b1);
        pop_check(done ? 1 : 0, busy ? 1 : 0);
        start = 1'b1; op = OP_MOVA; in_a = 8'h3C; in_b = 8'h00;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_mova:done", done, 1'b1);
        pop_check(done ? 1 : 0, busy ? 1 : 0);
        @(negedge clk);
        chk("b2b:pulse_end", done, 1'b0);

        run_op("clr",    OP_CLR,  3'b000,   8'h55, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1, 1, 0, 0);
        run_op("sub_bw", OP_SUB,  3'b000,   8'h00, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b1, 1, 1, 0, 0);
`ifdef ALU_SEQ_DIV_EN
        run_op("div",    OP_EXT,  MOP_DIV,  8'hC8, 8'h07, 8'h1C, 8'h04, 1'b0, 1'b0, 1, 9, 8, 0);
        run_op("div_0",  OP_EXT,  MOP_DIV,  8'h09, 8'h00, 8'hFF, 8'h09, 1'b0, 1'b1, 1, 9, 8, 0);
`else
        run_op("nop_001", OP_EXT, MOP_DIV,  8'h09, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1, 1, 1, 0, 0);
`endif
        run_op("nop_010", OP_EXT, 3'b010,   8'h09, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1, 1, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
